// File: rtl/ps2_pkg.sv
// Shared constants, frame-state encoding and parity helper for the PS/2 key receiver.
package ps2_pkg;

  localparam logic [7:0]  PS2_BREAK      = 8'hF0;
  localparam logic [7:0]  PS2_EXTEND     = 8'hE0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  // A frame is good when the 8 data bits plus the parity bit XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// PS/2 pins in, decoded key and frame status out.
interface ps2_key_receiver_if;

  logic       Ps2Clk;
  logic       Ps2Data;
  logic [7:0] KeyboardData;
  logic       Enable;
  logic       FrameValid;
  logic       FrameError;

  modport master (
    output Ps2Clk, Ps2Data,
    input  KeyboardData, Enable, FrameValid, FrameError
  );

  modport slave (
    input  Ps2Clk, Ps2Data,
    output KeyboardData, Enable, FrameValid, FrameError
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// Synchronises the PS/2 pins, assembles 11-bit frames on Ps2Clk falling edges and
// reports each completed byte as a single-cycle valid or error strobe.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int unsigned DATA_BITS = PS2_FRAME_BITS - 3;
  localparam int unsigned TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          fall;
  logic          bit_in;

  frame_state_t  state_q;
  frame_state_t  state_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  // Synchronisers idle high so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign bit_in  = data_sync[1];
  // A falling edge in the terminal-count cycle takes priority over the timeout.
  assign tmo_hit = (state_q != IDLE) && !fall && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:    if (!bit_in) state_d = DATA;
        DATA:    if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      if (fall || tmo_hit || state_q == IDLE) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (fall) begin
        unique case (state_q)
          IDLE:    bit_cnt_q <= '0;
          DATA: begin
            shift_q   <= {bit_in, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          PARITY:  parity_q <= bit_in;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rx_byte  = shift_q;
    rx_valid = 1'b0;
    rx_error = tmo_hit;
    if (fall && state_q == STOP) begin
      if (bit_in && odd_parity_ok(shift_q, parity_q)) begin
        rx_valid = 1'b1;
      end else begin
        rx_error = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: tracks make/break/extended prefixes on validated bytes and
// presents the currently held non-extended key with a level Enable.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic               Clock,
  input  logic               Reset_n,
  ps2_key_receiver_if.slave  bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;

  logic [7:0] key_q;
  logic       en_q;
  logic       brk_q;
  logic       ext_q;
  logic       valid_q;
  logic       error_q;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .ps2_clk  (bus.Ps2Clk),
    .ps2_data (bus.Ps2Data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_error (rx_error)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      key_q   <= '0;
      en_q    <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= rx_valid;
      error_q <= rx_error;
      if (rx_error) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == PS2_EXTEND) begin
          ext_q <= 1'b1;
        end else if (rx_byte == PS2_BREAK) begin
          brk_q <= 1'b1;
        end else if (ext_q) begin
          // Extended make and extended break both end here; the lookup has no such keys.
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end else if (brk_q) begin
          brk_q <= 1'b0;
          if (en_q && rx_byte == key_q) begin
            key_q <= '0;
            en_q  <= 1'b0;
          end
        end else begin
          key_q <= rx_byte;
          en_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.KeyboardData = key_q;
  assign bus.Enable       = en_q;
  assign bus.FrameValid   = valid_q;
  assign bus.FrameError   = error_q;

endmodule
